mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 161 ++++++++++++++++
 tb/tb_mac_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: sequences a dot product of up to DEPTH signed 8-bit operand pairs
// through an external multiply-accumulate unit.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   wr_en, wr_addr      operand buffer write strobe/address (honoured in IDLE only)
//   wr_a, wr_b          signed operand A/B write data
//   start, len          begin a run of min(len,16) pairs (sampled in IDLE only)
//   busy                high in every state except IDLE
//   done                one-cycle pulse when result is valid
//   result              signed captured accumulator, held until next capture
//   mac_a, mac_b        signed operands driven to the external MAC
//   mac_clr_n           active-low clear to the external MAC
//   mac_acc             external MAC accumulator
//
// Build option: define MAC_SEQ_SAT_EN to saturate the captured value to
// [-32768, 32767] (sign-extended); otherwise mac_acc is captured unmodified.

module mac_seq #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_a,
  input  logic [7:0]  wr_b,
  input  logic        start,
  input  logic [4:0]  len,
  output logic        busy,
  output logic        done,
  output logic [25:0] result,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic        mac_clr_n,
  input  logic [25:0] mac_acc
);

  localparam int unsigned AW = 4;
  localparam int unsigned NW = 5;
  localparam int unsigned RW = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] index_q, index_d;
  logic [RW-1:0] result_q, result_d;
  logic          done_q;
  logic          busy_q;

  logic [7:0] buf_a [DEPTH];
  logic [7:0] buf_b [DEPTH];

  // Value loaded into result at the end of DRAIN.
  function automatic logic [RW-1:0] capture(input logic [RW-1:0] acc);
`ifdef MAC_SEQ_SAT_EN
    if ($signed(acc) > $signed(RW'(32767))) begin
      return RW'(32767);
    end else if ($signed(acc) < $signed(-RW'(32768))) begin
      return -RW'(32768);
    end else begin
      return acc;
    end
`else
    return acc;
`endif
  endfunction

  // Operand buffer: no reset, so contents survive rst; writes only in IDLE.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      buf_a[wr_addr] <= wr_a;
      buf_b[wr_addr] <= wr_b;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    index_d  = index_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = (len > NW'(DEPTH)) ? NW'(DEPTH) : len;
          index_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = (n_q != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        index_d = index_q + NW'(1);
        // index_d counts completed RUN cycles; leave after exactly n of them
        if (index_d == n_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        result_d = capture(mac_acc);
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      index_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      index_q  <= index_d;
      result_q <= result_d;
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  // MAC interface decodes from state and index only; buffer read is combinational.
  always_comb begin
    mac_clr_n = 1'b1;
    mac_a     = '0;
    mac_b     = '0;
    unique case (state_q)
      S_CLEAR: mac_clr_n = 1'b0;
      S_RUN: begin
        mac_a = buf_a[index_q[AW-1:0]];
        mac_b = buf_b[index_q[AW-1:0]];
      end
      default: begin
        mac_clr_n = 1'b1;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: models the external MAC, and checks each run against
// a reference dot product computed from a shadow copy of the operand buffer.
module tb_mac_seq;

  logic               clk;
  logic               rst;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic [7:0]         wr_a;
  logic [7:0]         wr_b;
  logic               start;
  logic [4:0]         len;
  logic               busy;
  logic               done;
  logic signed [25:0] result;
  logic signed [7:0]  mac_a;
  logic signed [7:0]  mac_b;
  logic               mac_clr_n;
  logic signed [25:0] mac_acc;

  int n_pass  = 0;
  int n_check = 0;

  int ref_a [16];
  int ref_b [16];

  mac_seq #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr_n (mac_clr_n),
    .mac_acc   (mac_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MAC behaviour.
  always @(posedge clk) begin
    if (!mac_clr_n) mac_acc <= '0;
    else            mac_acc <= mac_acc + 26'(mac_a * mac_b);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int a, input int b);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_a    = 8'(a);
    wr_b    = 8'(b);
    tick();
    wr_en   = 1'b0;
    ref_a[addr] = a;
    ref_b[addr] = b;
  endtask

  function automatic longint expected_result(input int len_v);
    longint sum = 0;
    int     n   = (len_v > 16) ? 16 : len_v;
    for (int i = 0; i < n; i++) sum += longint'(ref_a[i]) * longint'(ref_b[i]);
`ifdef MAC_SEQ_SAT_EN
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
`endif
    return sum;
  endfunction

  // One run from IDLE; optional poke attempts start/write while busy.
  task automatic do_run(input string tag, input int len_v, input bit poke);
    int     n        = (len_v > 16) ? 16 : len_v;
    longint exp_res  = expected_result(len_v);
    int     done_cyc = -1;
    int     clr_low  = 0;
    int     not_busy = 0;
    start = 1'b1;
    len   = 5'(len_v);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!mac_clr_n) clr_low++;
      if (!busy) not_busy++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (poke && c == 3) begin
        start   = 1'b1;
        len     = 5'd1;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_a    = 8'h11;
        wr_b    = 8'h22;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
    chk({tag, " done latency"}, done_cyc, n + 3);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " clr_n low cycles"}, clr_low, 1);
    chk({tag, " busy while running"}, not_busy, 0);
    tick();
    chk({tag, " done one cycle"}, done, 0);
    chk({tag, " idle after done"}, busy, 0);
    chk({tag, " result held"}, result, exp_res);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " result"}, result, 0);
    chk({tag, " mac_clr_n"}, mac_clr_n, 1);
    chk({tag, " mac_a"}, mac_a, 0);
    chk({tag, " mac_b"}, mac_b, 0);
  endtask

  initial begin
    int done_count;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_a    = '0;
    wr_b    = '0;
    start   = 1'b0;
    len     = '0;
    mac_acc = '0;
    for (int i = 0; i < 16; i++) begin
      ref_a[i] = 0;
      ref_b[i] = 0;
    end
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic small dot product
    wr(0, 2, 5);
    wr(1, -2, 5);
    wr(2, -3, 8);
    do_run("basic", 3, 1'b0);
    chk("basic literal", result, -24);

    // Positive overflow of 16-bit range
    for (int i = 0; i < 3; i++) wr(i, 126, 126);
    do_run("pos_big", 3, 1'b0);
`ifdef MAC_SEQ_SAT_EN
    chk("pos_big literal", result, 32767);
`else
    chk("pos_big literal", result, 47628);
`endif

    // Negative overflow of 16-bit range
    for (int i = 0; i < 3; i++) wr(i, -128, 127);
    do_run("neg_big", 3, 1'b0);
`ifdef MAC_SEQ_SAT_EN
    chk("neg_big literal", result, -32768);
`else
    chk("neg_big literal", result, -48768);
`endif

    // Full buffer, len clamped, start and write while busy ignored
    for (int i = 0; i < 16; i++) wr(i, -128, -128);
    do_run("full_clamp", 31, 1'b1);
`ifndef MAC_SEQ_SAT_EN
    chk("full_clamp literal", result, 262144);
`endif
    chk("busy write ignored", dut.buf_a[0], 8'h80);

    // Zero length
    do_run("len0", 0, 1'b0);

    // Reset during second RUN cycle
    wr(0, 2, 5);
    wr(1, -2, 5);
    wr(2, -3, 8);
    start = 1'b1;
    len   = 5'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    tick();
    rst = 1'b0;
    done_count = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) done_count++;
      tick();
    end
    chk("midrun_rst no done", done_count, 0);
    do_run("after_rst", 3, 1'b0);
    chk("after_rst literal", result, -24);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        wr(i, int'($signed(8'($urandom))), int'($signed(8'($urandom))));
      end
      do_run($sformatf("rand%0d", r), int'($urandom_range(0, 31)), r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
